// File: rtl/vip_sobel_edge_3x3.sv
// 3x3 Sobel gradient magnitude / edge flag with matched-latency sync passthrough
// and a per-frame edge-pixel counter reported on the falling edge of post vsync.
module vip_sobel_edge_3x3 #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic             matrix_frame_clken,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       edge_threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [7:0]       post_img_mag,
  output logic             post_img_bit,
  output logic [CNT_W-1:0] frame_edge_cnt,
  output logic             frame_done
);

  logic [9:0]       r_gx_pos, r_gx_neg, r_gy_pos, r_gy_neg;
  logic [9:0]       r_gx_abs, r_gy_abs;
  logic [2:0]       r_vs, r_hr, r_ck, r_qvs;
  logic             r_vs_in_d, r_in_low_seen, r_pvs_d, r_qvs_d;
  logic [7:0]       r_thr, r_mag;
  logic             r_bit;
  logic [CNT_W-1:0] r_cnt, r_frame_cnt;
  logic             r_done;

  logic [10:0]      w_sum;
  logic [7:0]       w_mag;
  logic             w_bit;
  logic             w_qvs_in, w_post_rise, w_qfall, w_count;

  function automatic logic [9:0] f_w121(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [9:0] f_absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Qualified vsync only rises after a genuine low has been seen since reset,
  // so a frame already in progress at reset release is never reported.
  assign w_qvs_in    = matrix_frame_vsync & r_in_low_seen;
  assign w_post_rise = r_vs[2] & ~r_pvs_d;
  assign w_qfall     = ~r_qvs[2] & r_qvs_d;
  assign w_count     = r_vs[2] & r_hr[2] & r_ck[2] & r_bit;

  always_comb begin
    w_sum = {1'b0, r_gx_abs} + {1'b0, r_gy_abs};
    w_mag = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
    w_bit = (w_sum > {3'b000, r_thr});
    if (!r_hr[1]) begin
      w_mag = '0;
      w_bit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gx_pos <= '0;
      r_gx_neg <= '0;
      r_gy_pos <= '0;
      r_gy_neg <= '0;
      r_gx_abs <= '0;
      r_gy_abs <= '0;
      r_mag    <= '0;
      r_bit    <= 1'b0;
      r_vs     <= '0;
      r_hr     <= '0;
      r_ck     <= '0;
      r_qvs    <= '0;
    end else begin
      r_gx_pos <= f_w121(matrix_p13, matrix_p23, matrix_p33);
      r_gx_neg <= f_w121(matrix_p11, matrix_p21, matrix_p31);
      r_gy_pos <= f_w121(matrix_p11, matrix_p12, matrix_p13);
      r_gy_neg <= f_w121(matrix_p31, matrix_p32, matrix_p33);
      r_gx_abs <= f_absdiff(r_gx_pos, r_gx_neg);
      r_gy_abs <= f_absdiff(r_gy_pos, r_gy_neg);
      r_mag    <= w_mag;
      r_bit    <= w_bit;
      r_vs     <= {r_vs[1:0], matrix_frame_vsync};
      r_hr     <= {r_hr[1:0], matrix_frame_href};
      r_ck     <= {r_ck[1:0], matrix_frame_clken};
      r_qvs    <= {r_qvs[1:0], w_qvs_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_in_d     <= 1'b0;
      r_in_low_seen <= 1'b0;
      r_thr         <= '0;
    end else begin
      r_vs_in_d <= matrix_frame_vsync;
      if (!matrix_frame_vsync) r_in_low_seen <= 1'b1;
      if (matrix_frame_vsync && !r_vs_in_d) r_thr <= edge_threshold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pvs_d     <= 1'b0;
      r_qvs_d     <= 1'b0;
      r_cnt       <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_pvs_d <= r_vs[2];
      r_qvs_d <= r_qvs[2];
      if (w_post_rise)                 r_cnt <= '0;
      else if (w_count && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_qfall) begin
        r_frame_cnt <= r_cnt;
        r_done      <= 1'b1;
      end else begin
        r_done      <= 1'b0;
      end
    end
  end

  assign post_frame_vsync = r_vs[2];
  assign post_frame_href  = r_hr[2];
  assign post_frame_clken = r_ck[2];
  assign post_img_mag     = r_mag;
  assign post_img_bit     = r_bit;
  assign frame_edge_cnt   = r_frame_cnt;
  assign frame_done       = r_done;

endmodule

// File: tb/tb_vip_sobel_edge_3x3.sv
// Randomized scoreboard bench for vip_sobel_edge_3x3: driver pushes expected
// pixel results and frame counts, a negedge monitor pops and compares.
module tb_vip_sobel_edge_3x3;
  localparam int unsigned CNT_W = 21;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [7:0]       px[3][3];
  logic [7:0]       thr_in = '0;
  logic             o_vs, o_hr, o_ck, o_bit, o_done;
  logic [7:0]       o_mag;
  logic [CNT_W-1:0] o_cnt;

  typedef struct { int mag; int eb; } exp_t;
  exp_t sbq[$];
  int   fq[$];
  int   total = 0;
  int   bad = 0;

  // driver-side reference state
  int   prev_vs = 0, low_seen = 0, genuine = 0, cur_thr = 0, cnt_m = 0;

  always #5 clk = ~clk;

  vip_sobel_edge_3x3 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .matrix_frame_vsync(vs), .matrix_frame_href(hr), .matrix_frame_clken(ck),
    .matrix_p11(px[0][0]), .matrix_p12(px[0][1]), .matrix_p13(px[0][2]),
    .matrix_p21(px[1][0]), .matrix_p22(px[1][1]), .matrix_p23(px[1][2]),
    .matrix_p31(px[2][0]), .matrix_p32(px[2][1]), .matrix_p33(px[2][2]),
    .edge_threshold(thr_in),
    .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ck),
    .post_img_mag(o_mag), .post_img_bit(o_bit),
    .frame_edge_cnt(o_cnt), .frame_done(o_done)
  );

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  // 0 random, 1 uniform 100, 2 vertical edge, 3 right column 10, 4 binary random
  task automatic fill(input int mode);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        case (mode)
          1: px[r][c] = 8'd100;
          2: px[r][c] = (c == 0) ? 8'd0 : (c == 1) ? 8'd128 : 8'd255;
          3: px[r][c] = (c == 2) ? 8'd10 : 8'd0;
          4: px[r][c] = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
          default: px[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic cyc(input int v, input int h, input int k, input int mode);
    int w[3][3];
    int gx, gy, sum;
    exp_t e;
    fill(mode);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = int'(px[r][c]);
    if (v != 0 && prev_vs == 0) begin
      cur_thr = int'(thr_in);
      cnt_m   = 0;
      genuine = low_seen;
    end
    if (v == 0 && prev_vs != 0 && genuine != 0) begin
      fq.push_back(cnt_m);
      genuine = 0;
    end
    if (v == 0) low_seen = 1;
    gx  = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
    gy  = (w[0][0] + 2 * w[0][1] + w[0][2]) - (w[2][0] + 2 * w[2][1] + w[2][2]);
    sum = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    e.mag = (h != 0) ? ((sum > 255) ? 255 : sum) : 0;
    e.eb  = (h != 0 && sum > cur_thr) ? 1 : 0;
    if (h != 0 || k != 0) sbq.push_back(e);
    if (v != 0 && h != 0 && k != 0 && e.eb != 0) cnt_m++;
    prev_vs = v;
    vs = v[0]; hr = h[0]; ck = k[0];
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    prev_vs = 0; low_seen = 0; genuine = 0; cnt_m = 0; cur_thr = 0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // lines x width valid pixels; first 'hot' valid pixels are vertical edges;
  // midthr >= 0 changes edge_threshold halfway through the frame
  task automatic frame(input int lines, input int width, input int mode, input int thr,
                       input int hot, input int gap_lo, input int midthr);
    int hot_left, got;
    hot_left = hot;
    thr_in = 8'(thr);
    repeat (gap_lo) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int l = 0; l < lines; l++) begin
      if (midthr >= 0 && l == lines / 2) thr_in = 8'(midthr);
      got = 0;
      while (got < width) begin
        if ($urandom_range(0, 3) != 0) begin
          cyc(1, 1, 1, (hot_left > 0) ? 2 : mode);
          if (hot_left > 0) hot_left--;
          got++;
        end else begin
          cyc(1, 1, 0, 0);
        end
      end
      repeat ($urandom_range(1, 3)) cyc(1, 0, 0, 0);
    end
  endtask

  // monitor
  initial begin
    logic [2:0] sh[3];
    int nvalid;
    int prev_fd;
    exp_t e;
    nvalid = 0;
    prev_fd = 0;
    for (int i = 0; i < 3; i++) sh[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", int'({o_vs, o_hr, o_ck, o_bit, o_done, o_mag}) + int'(o_cnt), 0);
        nvalid = 0;
      end else begin
        if (nvalid >= 3) chk("sync_delay3", int'({o_vs, o_hr, o_ck}), int'(sh[2]));
        sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = {vs, hr, ck};
        nvalid++;
        if (o_hr || o_ck) begin
          if (sbq.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("mag", int'(o_mag), e.mag);
            chk("bit", int'(o_bit), e.eb);
          end
        end else begin
          chk("idle_zero", int'(o_mag) + int'(o_bit), 0);
        end
        if (o_done) begin
          chk("done_width", prev_fd, 0);
          if (fq.size() == 0) chk("unexpected_frame_done", 1, 0);
          else chk("frame_edge_cnt", int'(o_cnt), fq.pop_front());
        end
      end
      prev_fd = int'(o_done);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    fill(0);
    do_reset(3);
    repeat (2) cyc(0, 0, 0, 0);
    frame(1, 16, 1, 10, 0, 2, -1);            // uniform: mag 0
    frame(2, 10, 2, 50, 0, 2, -1);            // vertical edge: saturate
    frame(2, 8, 3, 40, 0, 2, -1);             // sum 40 vs thr 40
    frame(2, 8, 3, 39, 0, 2, -1);             // sum 40 vs thr 39
    frame(4, 12, 0, 200, 0, 2, 0);            // mid-frame threshold change
    frame(4, 12, 0, 0, 0, 2, -1);             // new threshold applies
    frame(4, 8, 1, 50, 5, 2, -1);             // exactly five edge pixels
    frame(4, 8, 1, 0, 0, 2, -1);              // zero count
    frame(3, 10, 4, 100, 0, 1, -1);           // back-to-back, 1-cycle gap
    frame(3, 10, 0, 60, 0, 1, -1);
    // frame broken by reset
    thr_in = 8'd30;
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (8) cyc(1, 1, 1, 0);
    repeat (4) cyc(1, 0, 0, 0);
    do_reset(2);
    repeat (5) cyc(1, 0, 0, 0);
    frame(4, 10, 4, 90, 0, 3, -1);
    for (int i = 0; i < 6; i++)
      frame($urandom_range(2, 6), $urandom_range(4, 12), $urandom_range(0, 4),
            $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(1, 3), -1);
    repeat (8) cyc(0, 0, 0, 0);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("frames_reported", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
